// File: rtl/flag_branch_unit.sv
// ============================================================================
// flag_branch_unit : Z/V/N flag register, conditional branch resolver with a
//                    one-entry valid/ready output register, overflow counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module flag_branch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] result,
    input  logic        posOvfl,
    input  logic        negOvfl,
    input  logic        wrAll,
    input  logic        wrZ,
    input  logic        brValid,
    output logic        brReady,
    input  logic [2:0]  ccc,
    input  logic [15:0] pcPlus2,
    input  logic [8:0]  offset,
    output logic        outValid,
    input  logic        outReady,
    output logic        taken,
    output logic [15:0] nextPc,
    output logic [2:0]  flags,
    output logic [15:0] ovflCount,
    input  logic        cntClr,
    input  logic        flush
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  flags_q, flags_d;
    logic        taken_q, taken_d;
    logic [15:0] next_pc_q, next_pc_d;
    logic [15:0] ovfl_count_q, ovfl_count_d;

    logic        flag_z, flag_v, flag_n;
    logic        cond_met;
    logic        accept;
    logic        ovfl_event;
    logic [15:0] target;

    assign flag_z = flags_q[2];
    assign flag_v = flags_q[1];
    assign flag_n = flags_q[0];

    // Held low during reset even though the state register already reads EMPTY.
    assign brReady    = rst_n & ((state_q == EMPTY) | outReady);
    assign accept     = brValid & brReady & ~flush;
    assign ovfl_event = wrAll & (posOvfl | negOvfl);
    assign target     = pcPlus2 + {{6{offset[8]}}, offset, 1'b0};

    always_comb begin
        cond_met = 1'b0;
        case (ccc)
            3'b000:  cond_met = ~flag_z;
            3'b001:  cond_met = flag_z;
            3'b010:  cond_met = ~flag_z & ~flag_n;
            3'b011:  cond_met = flag_n;
            3'b100:  cond_met = flag_z | (~flag_z & ~flag_n);
            3'b101:  cond_met = flag_z | flag_n;
            3'b110:  cond_met = flag_v;
            default: cond_met = 1'b1;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (wrAll) begin
            flags_d = {(result == 16'h0000), (posOvfl | negOvfl), result[15]};
        end else if (wrZ) begin
            flags_d[2] = (result == 16'h0000);
        end
    end

    always_comb begin
        state_d   = state_q;
        taken_d   = taken_q;
        next_pc_d = next_pc_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d   = FULL;
            taken_d   = cond_met;
            next_pc_d = cond_met ? target : pcPlus2;
        end else if (outReady) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        ovfl_count_d = ovfl_count_q;
        if (cntClr) begin
            ovfl_count_d = 16'h0000;
        end else if (ovfl_event && (ovfl_count_q != 16'hFFFF)) begin
            ovfl_count_d = ovfl_count_q + 16'h0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            flags_q      <= 3'b000;
            taken_q      <= 1'b0;
            next_pc_q    <= 16'h0000;
            ovfl_count_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            flags_q      <= flags_d;
            taken_q      <= taken_d;
            next_pc_q    <= next_pc_d;
            ovfl_count_q <= ovfl_count_d;
        end
    end

    assign outValid  = (state_q == FULL);
    assign taken     = taken_q;
    assign nextPc    = next_pc_q;
    assign flags     = flags_q;
    assign ovflCount = ovfl_count_q;

endmodule

`default_nettype wire

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port result, input, 16 bits: saturated result from the 16-bit saturating add/sub unit.
REQ-004 SHALL have ports posOvfl, negOvfl, input, 1 bit each: overflow flags from the same add/sub operation.
REQ-005 SHALL have port wrAll, input, 1 bit: write Z, V and N for an ADD/SUB commit.
REQ-006 SHALL have port wrZ, input, 1 bit: write Z only (logic/shift commit); ignored when wrAll=1.
REQ-007 SHALL have port brValid, input, 1 bit: a branch request is presented.
REQ-008 SHALL have port brReady, output, 1 bit: the unit can accept a branch request.
REQ-009 SHALL have port ccc, input, 3 bits: branch condition code.
REQ-010 SHALL have port pcPlus2, input, 16 bits: address of the instruction following the branch.
REQ-011 SHALL have port offset, input, 9 bits: signed branch offset in words.
REQ-012 SHALL have ports outValid/outReady, output/input, 1 bit each: resolved-branch handshake.
REQ-013 SHALL have port taken, output, 1 bit; and nextPc, output, 16 bits: the resolved branch.
REQ-014 SHALL have port flags, output, 3 bits {Z,V,N}: registered flag state.
REQ-015 SHALL have port ovflCount, output, 16 bits; and cntClr, input, 1 bit: overflow event counter and its synchronous clear.
REQ-016 SHALL have port flush, input, 1 bit: discard the pending and accepted branches.

Function
REQ-017 SHALL, on a wrAll commit, load Z=(result==0), V=posOvfl|negOvfl and N=result[15].
REQ-018 SHALL, on a wrZ commit without wrAll, load Z only and hold V and N.
REQ-019 SHALL, when neither wrAll nor wrZ is asserted, hold all flags.
REQ-020 SHALL evaluate branches against the registered flags only; a flag write in the same cycle as a branch accept is not visible to that branch.
REQ-021 SHALL decode ccc as follows:
- 000 Z=0
- 001 Z=1
- 010 Z=0&N=0
- 011 N=1
- 100 Z=1|(Z=0&N=0)
- 101 Z=1|N=1
- 110 V=1
- 111 always
REQ-022 SHALL compute the target as pcPlus2 + (sign-extended offset << 1), modulo 2^16 and without saturation.
REQ-023 SHALL drive nextPc = target when taken=1, and nextPc = pcPlus2 otherwise.
REQ-024 SHALL implement a two-state FSM, EMPTY and FULL, for the output register.
REQ-025 SHALL define brReady = (state==EMPTY) | outReady.
REQ-026 SHALL register taken/nextPc on accept (brValid&brReady) and assert outValid the next cycle, giving 1-cycle latency.
REQ-027 SHALL transition FULL -> EMPTY on outReady without a new accept, and stay FULL on a simultaneous accept (back-to-back, one per cycle).
REQ-028 SHALL hold outValid, taken and nextPc stable while FULL and outReady=0.
REQ-029 SHALL, on flush, go to EMPTY next cycle and drop any same-cycle accept; flags and the counter are unaffected.
REQ-030 SHALL increment ovflCount by 1 on each wrAll commit with posOvfl|negOvfl, saturating at 16'hFFFF.
REQ-031 SHALL give cntClr priority over a same-cycle increment, yielding 0.

Reset
REQ-032 SHALL, while rst_n=0, force immediately: flags=3'b000, state EMPTY, outValid=0, taken=0, nextPc=16'h0000, ovflCount=16'h0000.
REQ-033 SHALL, on reset mid-handshake, lose the held branch, and SHALL deassert brReady only while rst_n=0.

Verification
REQ-034 SHALL cover: wrAll with result=16'h7FFF, posOvfl=1 -> flags {Z,V,N}=010, ovflCount=1; then ccc=110 -> taken=1.
REQ-035 SHALL cover: wrAll with result=0, then wrZ with result=5 -> Z=0, V/N unchanged; ccc=001 -> taken=0, nextPc=pcPlus2.
REQ-036 SHALL cover: pcPlus2=16'h0010, offset=9'h1FF, ccc=111 -> nextPc=16'h000E; offset=9'h0FF from 16'hFF00 -> 16'h00FE (wrap).
REQ-037 SHALL cover: outReady=0 for 3 cycles with brValid held -> brReady=0 and outputs stable; then back-to-back accepts with outReady=1 -> one result per cycle.
REQ-038 SHALL cover: ovflCount preloaded to 16'hFFFF by repeated overflows plus one more -> stays 16'hFFFF; cntClr together with an overflow -> 0.
REQ-039 SHALL cover: flush in the accept cycle, and rst_n low while FULL -> outValid=0 next cycle (flush) / immediately (reset).
